icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 99 +++++++++
 tb/tb_icache.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, 16-byte lines; hits are combinational, misses issue one line fetch.
// Miss latency: 1 cycle request + fetch time + 1 cycle fill; rdy=0 holds idle state but never drops a fill pulse.
module icache #(
  parameter int INDEX_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         if_valid,
  input  logic [31:0]  if_addr,
  output logic         if_hit,
  output logic [31:0]  if_inst,
  output logic         fc_valid,
  output logic [31:0]  fc_addr,
  input  logic         fc_done,
  input  logic [127:0] fc_line
);

  localparam int TAG_W = 28 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [127:0]       data_mem [LINES];

  logic [1:0]         off;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               launch;
  logic               fill;
  logic               unused_addr_lsb;

  assign off      = if_addr[3:2];
  assign idx      = if_addr[INDEX_W+3:4];
  assign tag      = if_addr[31:INDEX_W+4];
  assign fill_idx = fc_addr[INDEX_W+3:4];
  assign fill_tag = fc_addr[31:INDEX_W+4];
  assign unused_addr_lsb = ^if_addr[1:0];

  assign if_hit  = if_valid && valid[idx] && (tag_mem[idx] == tag);
  assign if_inst = data_mem[idx][{off, 5'b0} +: 32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A fill completes regardless of rdy; only a new launch waits for it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rdy && if_valid && !if_hit) state_nxt = MISS;
      MISS: if (fc_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    launch = 1'b0;
    fill   = 1'b0;
    case (state)
      IDLE: launch = rdy && if_valid && !if_hit;
      MISS: fill   = fc_done && !rst;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      fc_valid <= 1'b0;
      fc_addr  <= 32'h0;
    end else if (fill) begin
      valid[fill_idx] <= 1'b1;
      fc_valid        <= 1'b0;
    end else if (launch) begin
      fc_valid <= 1'b1;
      fc_addr  <= {if_addr[31:4], 4'h0};
    end
  end

  // Tag/data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fc_line;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected hit/inst and fetch addresses are queued at stimulus time, popped when the DUT answers.
module tb_icache;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic         if_valid;
  logic [31:0]  if_addr;
  logic         if_hit;
  logic [31:0]  if_inst;
  logic         fc_valid;
  logic [31:0]  fc_addr;
  logic         fc_done;
  logic [127:0] fc_line;

  int checks   = 0;
  int failures = 0;

  logic        exp_hit_q  [$];
  logic [31:0] exp_inst_q [$];
  logic [31:0] exp_req_q  [$];

  icache #(.INDEX_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .if_valid (if_valid),
    .if_addr  (if_addr),
    .if_hit   (if_hit),
    .if_inst  (if_inst),
    .fc_valid (fc_valid),
    .fc_addr  (fc_addr),
    .fc_done  (fc_done),
    .fc_line  (fc_line)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: word at byte address a holds bytes b..b+3, b folds address bits [11:8] in so aliasing lines differ.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00} + {a[11:8], 4'h0};
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = mem_word({a[31:4], w[1:0], 2'b00});
    return l;
  endfunction

  task automatic probe(input string tag, input logic [31:0] a, input logic hit);
    logic        eh;
    logic [31:0] ei;
    if_valid = 1'b1;
    if_addr  = a;
    exp_hit_q.push_back(hit);
    exp_inst_q.push_back(mem_word(a));
    #1;
    eh = exp_hit_q.pop_front();
    ei = exp_inst_q.pop_front();
    check({tag, ".hit"}, {31'b0, if_hit}, {31'b0, eh});
    if (eh) check({tag, ".inst"}, if_inst, ei);
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    #1;
    while (!fc_valid && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, ".req"}, {31'b0, fc_valid}, 32'd1);
    check({tag, ".fc_addr"}, fc_addr, exp_req_q.pop_front());
  endtask

  task automatic done();
    fc_done = 1'b1;
    fc_line = line_of(fc_addr);
    @(negedge clk);
    fc_done = 1'b0;
  endtask

  task automatic miss_fill(input string tag, input logic [31:0] a);
    exp_req_q.push_back({a[31:4], 4'h0});
    probe({tag, ".miss"}, a, 1'b0);
    wait_req(tag);
    done();
    probe({tag, ".fill"}, a, 1'b1);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; if_valid = 1'b0; if_addr = '0;
    fc_done = 1'b0; fc_line = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.fc_valid", {31'b0, fc_valid}, 32'd0);
    check("reset.fc_addr", fc_addr, 32'h0);
    @(negedge clk);

    // Cold cache, stalled: everything misses and nothing is requested.
    probe("cold_stall_a", 32'h0000_0008, 1'b0);
    probe("cold_stall_b", 32'h0000_0200, 1'b0);
    #1 check("stall.no_req", {31'b0, fc_valid}, 32'd0);

    // Cold miss with the reference line.
    rdy = 1'b1;
    exp_req_q.push_back(32'h0000_0000);
    probe("cold", 32'h0000_0008, 1'b0);
    wait_req("cold");
    fc_done = 1'b1;
    fc_line = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    #1 check("cold.no_forward", {31'b0, if_hit}, 32'd0);
    @(negedge clk);
    fc_done = 1'b0;
    #1;
    check("cold.fc_valid_drop", {31'b0, fc_valid}, 32'd0);
    check("cold.hit", {31'b0, if_hit}, 32'd1);
    check("cold.inst", if_inst, 32'h0B0A0908);
    @(negedge clk);
    #1 check("cold.no_dup", {31'b0, fc_valid}, 32'd0);
    probe("align_b", 32'h0000_000B, 1'b1);
    probe("align_0", 32'h0000_0000, 1'b1);
    probe("align_c", 32'h0000_000C, 1'b1);

    // Conflict eviction at index 0.
    miss_fill("evict", 32'h0000_0200);
    exp_req_q.push_back(32'h0000_0000);
    probe("evict.old", 32'h0000_0000, 1'b0);
    wait_req("evict.old");
    done();
    probe("evict.refill", 32'h0000_0004, 1'b1);

    // Hit-under-miss, and a second miss that waits for IDLE.
    miss_fill("hum.line", 32'h0000_0010);
    exp_req_q.push_back(32'h0000_0040);
    probe("hum.miss", 32'h0000_0040, 1'b0);
    wait_req("hum");
    probe("hum.hit", 32'h0000_0014, 1'b1);
    check("hum.addr_held", fc_addr, 32'h0000_0040);
    probe("hum.miss2", 32'h0000_0080, 1'b0);
    #1;
    check("hum.no_new_req", fc_addr, 32'h0000_0040);
    check("hum.still_valid", {31'b0, fc_valid}, 32'd1);
    done();
    #1 check("hum.fill_drop", {31'b0, fc_valid}, 32'd0);
    exp_req_q.push_back(32'h0000_0080);
    wait_req("hum.second");
    done();
    probe("hum.second_hit", 32'h0000_0084, 1'b1);
    probe("hum.first_hit", 32'h0000_004C, 1'b1);

    // rdy low from request until after done.
    exp_req_q.push_back(32'h0000_0100);
    probe("stall", 32'h0000_0100, 1'b0);
    rdy = 1'b0;
    wait_req("stall");
    repeat (2) @(negedge clk);
    #1 check("stall.held", fc_addr, 32'h0000_0100);
    done();
    #1 check("stall.fc_valid_drop", {31'b0, fc_valid}, 32'd0);
    probe("stall.hit", 32'h0000_0108, 1'b1);
    rdy = 1'b1;
    probe("stall.resume", 32'h0000_0100, 1'b1);
    #1 check("stall.no_dup", {31'b0, fc_valid}, 32'd0);

    // Stray done while idle must not overwrite the line at fc_addr's index.
    if_valid = 1'b0;
    fc_done = 1'b1;
    fc_line = {128{1'b1}};
    @(negedge clk);
    fc_done = 1'b0;
    probe("idle_done", 32'h0000_0104, 1'b1);

    // Reset with a done pulse in the same cycle.
    exp_req_q.push_back(32'h0000_0300);
    probe("rstm", 32'h0000_0300, 1'b0);
    wait_req("rstm");
    rst = 1'b1;
    fc_done = 1'b1;
    fc_line = line_of(32'h0000_0300);
    @(negedge clk);
    rst = 1'b0;
    fc_done = 1'b0;
    rdy = 1'b0;
    #1;
    check("rstm.fc_valid", {31'b0, fc_valid}, 32'd0);
    check("rstm.fc_addr", fc_addr, 32'h0);
    probe("rstm.inv_8", 32'h0000_0008, 1'b0);
    probe("rstm.inv_10", 32'h0000_0010, 1'b0);
    probe("rstm.inv_40", 32'h0000_0040, 1'b0);
    probe("rstm.inv_80", 32'h0000_0080, 1'b0);
    probe("rstm.inv_100", 32'h0000_0100, 1'b0);
    probe("rstm.inv_200", 32'h0000_0200, 1'b0);
    probe("rstm.inv_300", 32'h0000_0300, 1'b0);
    rdy = 1'b1;
    miss_fill("rstm.again", 32'h0000_0300);

    if_valid = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
